sound_scheduler: RTL
====================

Name: sound_scheduler

Overview:
- Shares the single speaker tone generator between background music and three game sound effects: hard drop, line clear and game over.
- Drives the tone generator's half-period compare value (TONE_PERIOD) and enable (TONE_EN).
- Passes music through when idle. Plays fixed effect note sequences with strict priority and preemption.
- Sits between the music sequencer, the game FSM and the tone generator, on the 25 MHz domain.

Parameters:
- TICK_DIV, 250000, cycles per duration tick (10 ms at 25 MHz); minimum 2.
- PW, 16, width of period values.

Ports:
- CLK  in  1  system clock, 25 MHz.
- RESET  in  1  synchronous, active-high reset.
- SFX_REQ  in  3  one-cycle request pulses: bit0 drop, bit1 line clear, bit2 game over.
- MUSIC_EN  in  1  music pass-through enable.
- MUSIC_PERIOD  in  PW  current music half-period; 0 = rest.
- TONE_PERIOD  out  PW  half-period to tone generator; registered.
- TONE_EN  out  1  tone generator enable; registered.
- SFX_BUSY  out  1  effect in progress; registered.
- SFX_ID  out  2  effect currently loaded or playing (0..2); registered.
- SFX_DONE  out  1  one-cycle pulse when an effect completes unpreempted.

Behaviour:
- Reset: TONE_PERIOD=0, TONE_EN=0, SFX_BUSY=0, SFX_ID=0, SFX_DONE=0. Pending bits, tick counter and note index are cleared; state is IDLE. Reset mid-effect aborts the effect with no SFX_DONE.
- Effect tables (period, duration in ticks), fixed in RTL:
  - Drop (0): (36080, 3).
  - Line clear (1): (26840, 4), (23760, 4), (21120, 4).
  - Game over (2): (21120, 8), (26840, 8), (32120, 8), (43120, 16).
- Priority: 2 > 1 > 0.
- Pending latch:
  - SFX_REQ[i] at edge k sets pending[i]. Multiple bits may be set at once.
  - A request for the currently playing effect is ignored; no restart.
- States:
  - IDLE:
    - TONE_PERIOD=MUSIC_PERIOD when MUSIC_EN, else 0.
    - TONE_EN = MUSIC_EN & (MUSIC_PERIOD!=0).
    - SFX_BUSY=0.
    - Any pending bit -> LOAD.
  - LOAD (1 cycle):
    - Select the highest pending effect, clear its pending bit, set SFX_ID, note index=0, clear the tick counter.
    - TONE_EN=0, SFX_BUSY=1.
    - -> PLAY.
  - PLAY:
    - TONE_PERIOD = table period, TONE_EN=1.
    - Lasts exactly dur*TICK_DIV cycles; the tick counter restarts at each note start.
    - End of a non-final note -> GAP.
    - End of the final note -> LOAD if any pending, else IDLE. SFX_DONE=1 in that first following cycle.
  - GAP:
    - TONE_EN=0, TONE_PERIOD=0, lasts exactly TICK_DIV cycles.
    - -> PLAY with the next note index.
- Preemption:
  - In PLAY or GAP, a pending bit above SFX_ID -> LOAD next cycle.
  - The preempted effect is dropped: not resumed, no SFX_DONE.
  - Lower-priority pending bits stay latched and play afterwards, highest first.
- Request latency from IDLE: SFX_REQ at edge k -> pending after k, LOAD outputs after k+1, first note on TONE_PERIOD/TONE_EN after k+2.
- A request arriving in the same cycle LOAD clears a different bit is latched normally.
- Music changes during an effect are ignored. Pass-through resumes on the first IDLE cycle, with no memory of the interrupted note.
- Effect busy time = 1 + sum(dur)*TICK_DIV + (notes-1)*TICK_DIV cycles.

Test Plan:
- All directed scenarios use TICK_DIV=10.
- Reset then idle: MUSIC_EN=1, MUSIC_PERIOD=21120 -> TONE_EN=1, TONE_PERIOD=21120 one cycle after each change. MUSIC_PERIOD=0 -> TONE_EN=0.
- Line clear pulse at cycle k:
  - SFX_BUSY=1 from k+1 for 141 cycles.
  - TONE_PERIOD sequence 26840/0/23760/0/21120 with lengths 40/10/40/10/40.
  - SFX_DONE single pulse, then music restored.
- Preemption: drop request, then game over request 5 cycles into the drop note -> LOAD next cycle, SFX_ID=2, no SFX_DONE for drop, game-over busy time 431 cycles.
- Simultaneous SFX_REQ=3'b011 -> line clear plays first (SFX_ID=1), then LOAD, then drop (SFX_ID=0). Two SFX_DONE pulses; drop's busy window is 31 cycles.
- Line clear re-requested mid-effect -> ignored; total busy time still 141 cycles. A drop request mid-line-clear -> plays after, not preempting.
- RESET asserted mid-game-over note -> next cycle all outputs 0, pending cleared, no SFX_DONE. Later requests behave normally.

Source files
------------

// File: rtl/sound_scheduler.sv
// sound_scheduler
//   Shares the single speaker tone generator between background music and
//   three fixed game sound effects (drop, line clear, game over). Music is
//   passed straight through while idle; effects play fixed note tables with
//   strict priority (game over > line clear > drop) and preempt each other.
//
// Ports
//   CLK           system clock (25 MHz)
//   RESET         synchronous, active-high reset
//   SFX_REQ[2:0]  one-cycle request pulses: bit0 drop, bit1 line clear,
//                 bit2 game over
//   MUSIC_EN      music pass-through enable
//   MUSIC_PERIOD  current music half-period, 0 = rest
//   TONE_PERIOD   registered half-period to the tone generator
//   TONE_EN       registered tone generator enable
//   SFX_BUSY      registered, high while an effect is loaded or playing
//   SFX_ID        registered id (0..2) of the effect loaded or playing
//   SFX_DONE      one-cycle pulse when an effect completes unpreempted
//
// Handshake: SFX_REQ is a fire-and-forget pulse with no ready. A pulse is
// latched into a pending bit on the edge it is sampled, unless it names the
// effect already loaded or playing, in which case it is dropped.
//
// The state register is kept in the signal `state` (type state_t) so a
// checker can bind to it directly.

module sound_scheduler #(
    parameter int TICK_DIV = 250000,
    parameter int PW       = 16
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [2:0]    SFX_REQ,
    input  logic          MUSIC_EN,
    input  logic [PW-1:0] MUSIC_PERIOD,
    output logic [PW-1:0] TONE_PERIOD,
    output logic          TONE_EN,
    output logic          SFX_BUSY,
    output logic [1:0]    SFX_ID,
    output logic          SFX_DONE
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_GAP
    } state_t;

    // ------------------------------------------------------------------
    // Effect note tables
    // ------------------------------------------------------------------
    function automatic logic [PW-1:0] note_period(input logic [1:0] id,
                                                  input logic [1:0] idx);
        logic [PW-1:0] p;
        p = '0;
        case (id)
            2'd0: p = PW'(36080);
            2'd1: begin
                case (idx)
                    2'd0:    p = PW'(26840);
                    2'd1:    p = PW'(23760);
                    default: p = PW'(21120);
                endcase
            end
            default: begin
                case (idx)
                    2'd0:    p = PW'(21120);
                    2'd1:    p = PW'(26840);
                    2'd2:    p = PW'(32120);
                    default: p = PW'(43120);
                endcase
            end
        endcase
        return p;
    endfunction

    // Note duration in ticks.
    function automatic logic [4:0] note_dur(input logic [1:0] id,
                                            input logic [1:0] idx);
        logic [4:0] d;
        d = 5'd0;
        case (id)
            2'd0:    d = 5'd3;
            2'd1:    d = 5'd4;
            default: d = (idx == 2'd3) ? 5'd16 : 5'd8;
        endcase
        return d;
    endfunction

    function automatic logic [1:0] last_idx(input logic [1:0] id);
        logic [1:0] l;
        case (id)
            2'd0:    l = 2'd0;
            2'd1:    l = 2'd2;
            default: l = 2'd3;
        endcase
        return l;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t          state;
    state_t          next_state;
    logic [2:0]      pending;
    logic [2:0]      pending_next;
    logic [1:0]      note_idx;
    logic [1:0]      next_idx;
    logic [1:0]      next_id;
    logic [TW-1:0]   tick_cnt;   // cycles within the current tick
    logic [4:0]      tick_num;   // whole ticks elapsed in the current note/gap

    logic            tick_end;
    logic            note_end;
    logic            final_note;
    logic            higher_pending;
    logic [1:0]      top_id;
    logic [2:0]      clr_mask;
    logic [2:0]      active_mask;
    logic            done_d;
    logic [PW-1:0]   period_d;
    logic            en_d;
    logic            busy_d;

    assign tick_end   = (tick_cnt == TW'(TICK_DIV - 1));
    assign note_end   = tick_end && (tick_num == note_dur(SFX_ID, note_idx) - 5'd1);
    assign final_note = (note_idx == last_idx(SFX_ID));

    // Highest pending effect and whether anything outranks the current one.
    always_comb begin
        top_id = 2'd0;
        if (pending[2]) begin
            top_id = 2'd2;
        end else if (pending[1]) begin
            top_id = 2'd1;
        end

        higher_pending = 1'b0;
        case (SFX_ID)
            2'd0:    higher_pending = |pending[2:1];
            2'd1:    higher_pending = pending[2];
            default: higher_pending = 1'b0;
        endcase
    end

    // Next-state logic. Selecting an effect happens on the transition into
    // LOAD so that SFX_ID and the cleared pending bit are visible during
    // the LOAD cycle itself.
    always_comb begin
        next_state = state;
        next_id    = SFX_ID;
        next_idx   = note_idx;
        clr_mask   = 3'b000;
        done_d     = 1'b0;

        case (state)
            S_IDLE: begin
                if (|pending) begin
                    next_state = S_LOAD;
                    next_id    = top_id;
                    next_idx   = 2'd0;
                    clr_mask   = 3'b001 << top_id;
                end
            end
            S_LOAD: begin
                next_state = S_PLAY;
            end
            S_PLAY: begin
                // A final note that runs out is a completed effect even if a
                // higher request lands in the same cycle.
                if (note_end && final_note) begin
                    done_d = 1'b1;
                    if (|pending) begin
                        next_state = S_LOAD;
                        next_id    = top_id;
                        next_idx   = 2'd0;
                        clr_mask   = 3'b001 << top_id;
                    end else begin
                        next_state = S_IDLE;
                    end
                end else if (higher_pending) begin
                    next_state = S_LOAD;
                    next_id    = top_id;
                    next_idx   = 2'd0;
                    clr_mask   = 3'b001 << top_id;
                end else if (note_end) begin
                    next_state = S_GAP;
                end
            end
            S_GAP: begin
                if (higher_pending) begin
                    next_state = S_LOAD;
                    next_id    = top_id;
                    next_idx   = 2'd0;
                    clr_mask   = 3'b001 << top_id;
                end else if (tick_end) begin
                    next_state = S_PLAY;
                    next_idx   = note_idx + 2'd1;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Requests naming the effect being loaded now, or already loaded or
    // playing, are discarded so an effect never restarts itself.
    always_comb begin
        active_mask = 3'b000;
        if (state != S_IDLE) begin
            active_mask = 3'b001 << SFX_ID;
        end
        pending_next = (pending & ~clr_mask) | (SFX_REQ & ~active_mask & ~clr_mask);
    end

    // Output values for the cycle after the coming edge, derived from the
    // state being entered so every output is a plain register.
    always_comb begin
        period_d = '0;
        en_d     = 1'b0;
        busy_d   = 1'b1;
        case (next_state)
            S_IDLE: begin
                busy_d   = 1'b0;
                period_d = MUSIC_EN ? MUSIC_PERIOD : '0;
                en_d     = MUSIC_EN && (MUSIC_PERIOD != '0);
            end
            S_PLAY: begin
                period_d = note_period(next_id, next_idx);
                en_d     = 1'b1;
            end
            default: begin
                period_d = '0;
                en_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= S_IDLE;
            pending     <= 3'b000;
            note_idx    <= 2'd0;
            tick_cnt    <= '0;
            tick_num    <= 5'd0;
            TONE_PERIOD <= '0;
            TONE_EN     <= 1'b0;
            SFX_BUSY    <= 1'b0;
            SFX_ID      <= 2'd0;
            SFX_DONE    <= 1'b0;
        end else begin
            state       <= next_state;
            pending     <= pending_next;
            note_idx    <= next_idx;
            TONE_PERIOD <= period_d;
            TONE_EN     <= en_d;
            SFX_BUSY    <= busy_d;
            SFX_ID      <= next_id;
            SFX_DONE    <= done_d;

            // Tick counters restart on every state change, so each note and
            // each gap is timed from its own first cycle.
            if ((next_state != state) || (state == S_IDLE) || (state == S_LOAD)) begin
                tick_cnt <= '0;
                tick_num <= 5'd0;
            end else if (tick_end) begin
                tick_cnt <= '0;
                tick_num <= tick_num + 5'd1;
            end else begin
                tick_cnt <= tick_cnt + TW'(1);
            end
        end
    end

endmodule
